// File: rtl/keycode_pkg.sv
// Shared types and constants for the keycode event tracker.
// Event words are {ev_type_t, 8-bit USB keycode}.
package keycode_pkg;

    localparam int         EV_W     = 10;
    localparam logic [7:0] KEY_NONE = 8'h00;

    typedef enum logic [1:0] {
        EV_MAKE   = 2'b00,
        EV_BREAK  = 2'b01,
        EV_REPEAT = 2'b10
    } ev_type_t;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        MAK,
        COMMIT
    } scan_state_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO: dout is the oldest entry whenever empty is low.
// Valid/ready: an entry moves on a rising edge when push && !full (write) or pop && !empty (read).
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Flags come straight from the count register, so a pop does not free
    // a slot for a push in the same cycle.
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keycode_tracker.sv
// Turns raw keycode snapshots into ordered make/break/repeat events on a
// valid/ready stream: an event transfers on a rising edge with ev_valid && ev_ready.
module keycode_tracker
    import keycode_pkg::*;
#(
    parameter int SLOTS        = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 2_500_000
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [8*SLOTS-1:0]         keycode,
    output logic [EV_W-1:0]            ev_data,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic [$clog2(SLOTS+1)-1:0] held_count,
    output logic                       busy
);

    localparam int KW   = 8 * SLOTS;
    localparam int IW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int HW   = $clog2(SLOTS + 1);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] C_RATE   = CW'(REPEAT_RATE);
    localparam logic [IW-1:0] LAST_IDX = IW'(SLOTS - 1);

    function automatic logic [7:0] slot_of(input logic [KW-1:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    function automatic logic in_set(input logic [KW-1:0] v, input logic [7:0] code);
        logic found;
        found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (v[8*i +: 8] == code) found = 1'b1;
        end
        return found;
    endfunction

    function automatic logic dup_below(input logic [KW-1:0] v, input int idx, input logic [7:0] code);
        logic found;
        found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (i < idx && v[8*i +: 8] == code) found = 1'b1;
        end
        return found;
    endfunction

    scan_state_t     r_state;
    logic [IW-1:0]   r_idx;
    logic [KW-1:0]   r_kc_q;
    logic [KW-1:0]   r_prev;
    logic [KW-1:0]   r_snap;
    logic            r_armed;
    logic [CW-1:0]   r_rep_cnt;
    logic [7:0]      r_rep_code;

    logic [KW-1:0]   w_src;
    logic [KW-1:0]   w_ref;
    logic [7:0]      w_code;
    logic            w_new;
    logic            w_scanning;
    logic            w_scan_push;
    logic            w_step;
    logic            w_change;
    logic            w_rep_push;
    logic            w_push;
    logic [EV_W-1:0] w_push_data;
    logic            w_full;
    logic            w_empty;
    logic [EV_W-1:0] w_dout;
    logic [HW-1:0]   w_held;

    // BRK walks the committed set looking for codes gone from the snapshot;
    // MAK walks the snapshot looking for codes absent from the committed set.
    assign w_src       = (r_state == MAK) ? r_snap : r_prev;
    assign w_ref       = (r_state == MAK) ? r_prev : r_snap;
    assign w_code      = slot_of(w_src, int'(r_idx));
    assign w_new       = (w_code != KEY_NONE) && !in_set(w_ref, w_code)
                         && !dup_below(w_src, int'(r_idx), w_code);
    assign w_scanning  = (r_state == BRK) || (r_state == MAK);
    assign w_scan_push = w_scanning && w_new && !w_full;
    assign w_step      = w_scanning && (!w_new || !w_full);
    assign w_change    = (r_kc_q != r_prev);
    assign w_rep_push  = (r_state == IDLE) && !w_change && r_armed
                         && (r_rep_cnt == '0) && !w_full;
    assign w_push      = w_scan_push || w_rep_push;
    assign w_push_data = w_rep_push ? {EV_REPEAT, r_rep_code}
                                    : {((r_state == MAK) ? EV_MAKE : EV_BREAK), w_code};

    always_comb begin
        w_held = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_of(r_prev, i) != KEY_NONE && !dup_below(r_prev, i, slot_of(r_prev, i)))
                w_held = w_held + HW'(1);
        end
    end

    assign held_count = w_held;
    assign busy       = (r_state != IDLE);
    assign ev_valid   = !w_empty;
    assign ev_data    = w_empty ? '0 : w_dout;

    event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (w_push),
        .din     (w_push_data),
        .full    (w_full),
        .pop     (ev_ready),
        .empty   (w_empty),
        .dout    (w_dout)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_kc_q  <= '0;
            r_prev  <= '0;
            r_snap  <= '0;
        end else begin
            r_kc_q <= keycode;
            case (r_state)
                IDLE: begin
                    if (w_change) begin
                        r_snap  <= r_kc_q;
                        r_idx   <= '0;
                        r_state <= BRK;
                    end
                end
                BRK: begin
                    if (w_step) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= MAK;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                MAK: begin
                    if (w_step) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx   <= '0;
                            r_state <= COMMIT;
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
                COMMIT: begin
                    r_prev  <= r_snap;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A zero delay means repeat is disabled, so makes never arm the counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_armed    <= 1'b0;
            r_rep_cnt  <= '0;
            r_rep_code <= '0;
        end else if (w_scan_push && r_state == MAK && REPEAT_DELAY != 0) begin
            r_rep_code <= w_code;
            r_rep_cnt  <= C_DELAY;
            r_armed    <= 1'b1;
        end else if (w_scan_push && r_state == BRK && w_code == r_rep_code) begin
            r_armed <= 1'b0;
        end else if (w_rep_push) begin
            r_rep_cnt <= C_RATE;
        end else if (r_armed && r_rep_cnt != '0) begin
            r_rep_cnt <= r_rep_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_keycode_tracker.sv
// Directed bench for keycode_tracker: one instance with repeat enabled and
// one with repeat disabled, both SLOTS=2, FIFO_DEPTH=4.
module tb_keycode_tracker;
    import keycode_pkg::*;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset_n;
    logic [15:0] keycode, keycode2;
    logic        ev_ready, ev_ready2;
    logic [9:0]  ev_data, ev_data2;
    logic        ev_valid, ev_valid2;
    logic [1:0]  held_count, held_count2;
    logic        busy, busy2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0] obs_q[$];
    int         obs_t[$];
    logic [9:0] obs2_q[$];
    logic [9:0] exp_q[$];

    keycode_tracker #(
        .SLOTS(2), .FIFO_DEPTH(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
    ) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .ev_data(ev_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .held_count(held_count), .busy(busy)
    );

    keycode_tracker #(
        .SLOTS(2), .FIFO_DEPTH(4), .REPEAT_DELAY(0), .REPEAT_RATE(5)
    ) u_dut_nr (
        .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode2), .ev_data(ev_data2),
        .ev_valid(ev_valid2), .ev_ready(ev_ready2), .held_count(held_count2), .busy(busy2)
    );

    always @(posedge Clk) cyc <= cyc + 1;

    // Record every accepted event; inputs only change just after posedge.
    always @(negedge Clk) begin
        if (Reset_n && ev_valid && ev_ready) begin
            obs_q.push_back(ev_data);
            obs_t.push_back(cyc);
        end
        if (Reset_n && ev_valid2 && ev_ready2) obs2_q.push_back(ev_data2);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i]);
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_t.delete();
        obs2_q.delete();
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        keycode  = 16'h0000;
        keycode2 = 16'h0000;
        ev_ready = 1'b1;
        ev_ready2 = 1'b1;
        step(2);
        Reset_n = 1'b1;
        step(1);
        clear_obs();
    endtask

    task automatic wait_events(input int n, input int bound, input string tag);
        int k;
        k = 0;
        while (obs_q.size() < n && k < bound) begin
            step(1);
            k++;
        end
        if (obs_q.size() < n) check({tag, "_timeout"}, obs_q.size(), n);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int k;
        k = 0;
        while (busy && k < bound) begin
            step(1);
            k++;
        end
        if (busy) check({tag, "_busy_timeout"}, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0, n204, n216;
        logic [15:0] seq [5];

        // Reset values
        Reset_n = 1'b0; keycode = '0; keycode2 = '0; ev_ready = 1'b1; ev_ready2 = 1'b1;
        step(2);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_data", ev_data, 0);
        check("rst_held", held_count, 0);
        check("rst_busy", busy, 0);
        Reset_n = 1'b1;
        step(1);
        clear_obs();

        // Make 'A', then repeats at DELAY then RATE spacing
        c0 = cyc;
        keycode = 16'h0004;
        wait_events(1, 15, "make_a");
        if (obs_q.size() >= 1) begin
            check("make_a_data", obs_q[0], 10'h004);
            check("make_a_latency", obs_t[0] - c0, 5);
        end
        wait_idle(10, "make_a");
        check("make_a_held", held_count, 1);
        wait_events(3, 40, "repeat_a");
        if (obs_q.size() >= 3) begin
            check("repeat_a_data0", obs_q[1], 10'h204);
            check("repeat_a_data1", obs_q[2], 10'h204);
            check("repeat_a_delay", (obs_t[1] - obs_t[0] >= 20) && (obs_t[1] - obs_t[0] <= 21), 1);
            check("repeat_a_rate", (obs_t[2] - obs_t[1] >= 5) && (obs_t[2] - obs_t[1] <= 6), 1);
        end

        // Slot swap: break 'A' before make 0x16; repeat retargets
        clear_obs();
        keycode = 16'h1600;
        step(12);
        while (obs_q.size() > 0 && obs_q[0] == 10'h204) void'(obs_q.pop_front());
        exp_q = '{10'h104, 10'h016};
        compare_stream("swap");
        check("swap_held", held_count, 1);
        clear_obs();
        step(30);
        n204 = 0; n216 = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i] == 10'h204) n204++;
            if (obs_q[i] == 10'h216) n216++;
        end
        check("swap_no_old_repeat", n204, 0);
        check("swap_new_repeat", n216 >= 1, 1);

        // Duplicate code in both slots
        do_reset();
        keycode = 16'h0404;
        step(12);
        exp_q = '{10'h004};
        compare_stream("dup_make");
        check("dup_held", held_count, 1);
        clear_obs();
        keycode = 16'h0000;
        step(12);
        exp_q = '{10'h104};
        compare_stream("dup_break");
        check("dup_held_zero", held_count, 0);

        // Backpressure: fill the buffer, stall the scan, then drain in order
        do_reset();
        ev_ready = 1'b0;
        seq = '{16'h0004, 16'h0000, 16'h0004, 16'h0000, 16'h0004};
        for (int i = 0; i < 5; i++) begin
            keycode = seq[i];
            step(8);
        end
        check("bp_busy_stalled", busy, 1);
        check("bp_valid", ev_valid, 1);
        step(5);
        check("bp_busy_still", busy, 1);
        ev_ready = 1'b1;
        step(12);
        exp_q = '{10'h004, 10'h104, 10'h004, 10'h104, 10'h004};
        compare_stream("bp_drain");
        check("bp_busy_done", busy, 0);
        check("bp_held", held_count, 1);

        // Reset mid-scan with an event pending
        do_reset();
        ev_ready = 1'b0;
        keycode = 16'h0007;
        begin
            int k;
            k = 0;
            while (!ev_valid && k < 15) begin
                step(1);
                k++;
            end
            check("mid_pending", ev_valid, 1);
        end
        check("mid_scanning", busy, 1);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_busy", busy, 0);
        step(1);
        Reset_n = 1'b1;
        ev_ready = 1'b1;
        clear_obs();
        step(15);
        exp_q = '{10'h007};
        compare_stream("mid_after");
        check("mid_held", held_count, 1);

        // Repeat disabled: hold a key, only the make appears
        clear_obs();
        keycode2 = 16'h0004;
        step(200);
        check("norep_count", obs2_q.size(), 1);
        if (obs2_q.size() >= 1) check("norep_data", obs2_q[0], 10'h004);
        check("norep_held", held_count2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
